// File: rtl/piso_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : piso_pkg
//  Description : Shared definitions for the parallel-in, serial-out
//                serializer: FSM state encoding and the helper that sizes
//                the remaining-bit down-counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package piso_pkg;

  // FSM state encoding (1-bit state register)
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  // Width of a counter that must hold values 0 .. width-1.
  // Clamped to at least one bit so a degenerate width still elaborates.
  function automatic int cnt_width(input int width);
    if (width < 2) begin
      return 1;
    end
    return $clog2(width);
  endfunction

endpackage : piso_pkg
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : piso_serializer
//  Description : Parallel-in, serial-out shift register. Accepts a WIDTH-bit
//                word over a valid/ready handshake and emits it one bit per
//                clock on sout, honouring downstream back-pressure. A new
//                word may be accepted during the last-bit cycle, giving
//                gap-free streaming of consecutive words.
//  Revision    : 1.0 - initial release
//
//  Parameters
//    WIDTH      word length in bits (2..64)
//    MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//
//  Ports
//    clk         in   rising-edge clock
//    rst_n       in   asynchronous active-low reset
//    din         in   parallel word to serialize
//    din_valid   in   din is valid
//    din_ready   out  block can accept din this cycle
//    sout        out  serial data bit
//    sout_valid  out  sout carries a frame bit
//    sout_ready  in   downstream consumes sout this cycle
//    sout_last   out  current sout bit is the final bit of the word
//    busy        out  a word is in flight
// ============================================================================
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             sout_last,
  output logic             busy
);

  localparam int               CNT_W   = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  logic             state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic             shreg_shifted_bit_unused;
  logic [WIDTH-1:0] shreg_shifted;
  logic             out_bit;
  logic             accept;
  logic             xfer;

  // The output end of the shift register depends on bit order; the register
  // always shifts toward that end with zero fill.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shreg_shifted            = {shreg_q[WIDTH-2:0], 1'b0};
      assign out_bit                  = shreg_q[WIDTH-1];
      assign shreg_shifted_bit_unused = shreg_q[0];
    end else begin : g_lsb_first
      assign shreg_shifted            = {1'b0, shreg_q[WIDTH-1:1]};
      assign out_bit                  = shreg_q[0];
      assign shreg_shifted_bit_unused = shreg_q[WIDTH-1];
    end
  endgenerate

  assign accept = din_valid && din_ready;
  assign xfer   = (state_q == ST_SHIFT) && sout_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. An accept can only coincide with a bit transfer on the
  // last bit (din_ready needs sout_ready in SHIFT), so reloading takes
  // priority and naturally gives the zero-gap hand-over.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = ST_SHIFT;
      shreg_d = din;
      cnt_d   = CNT_MAX;
    end else if (xfer) begin
      shreg_d = shreg_shifted;
      if (cnt_q == '0) begin
        state_d = ST_IDLE;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Output logic, all derived from registered state plus sout_ready.
  always_comb begin
    busy       = (state_q == ST_SHIFT);
    sout_valid = (state_q == ST_SHIFT);
    sout       = (state_q == ST_SHIFT) && out_bit;
    sout_last  = (state_q == ST_SHIFT) && (cnt_q == '0);
    din_ready  = (state_q == ST_IDLE) || ((cnt_q == '0) && sout_ready);
  end

endmodule : piso_serializer
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piso_serializer
//  Description : Self-checking bench for piso_serializer. The main 8-bit
//                MSB-first instance is checked by a scoreboard: every
//                accepted word is expanded into its expected bit sequence
//                and a monitor compares what the DUT presents. Two extra
//                instances (LSB-first, WIDTH=2) get directed checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- main DUT: WIDTH=8, MSB first ----------------
  logic [7:0] din;
  logic       din_valid, din_ready, sout, sout_valid, sout_ready, sout_last, busy;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .sout(sout), .sout_valid(sout_valid),
    .sout_ready(sout_ready), .sout_last(sout_last), .busy(busy)
  );

  // ---------------- LSB-first DUT ----------------
  logic [7:0] l_din;
  logic       l_valid, l_dready, l_sout, l_svalid, l_sready, l_slast, l_busy;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .din(l_din), .din_valid(l_valid),
    .din_ready(l_dready), .sout(l_sout), .sout_valid(l_svalid),
    .sout_ready(l_sready), .sout_last(l_slast), .busy(l_busy)
  );

  // ---------------- WIDTH=2 DUT ----------------
  logic [1:0] w_din;
  logic       w_valid, w_dready, w_sout, w_svalid, w_sready, w_slast, w_busy;

  piso_serializer #(.WIDTH(2), .MSB_FIRST(1'b1)) u_w2 (
    .clk(clk), .rst_n(rst_n), .din(w_din), .din_valid(w_valid),
    .din_ready(w_dready), .sout(w_sout), .sout_valid(w_svalid),
    .sout_ready(w_sready), .sout_last(w_slast), .busy(w_busy)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- scoreboard for the main DUT ----------------
  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t exp_q[$];
  exp_t head;
  logic e_valid, e_ready;

  // Reference: an accepted word becomes 8 bits, MSB first, last flag on the
  // final one. The head of the queue is what the DUT must be presenting.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      e_valid = (exp_q.size() != 0);
      head    = e_valid ? exp_q[0] : exp_t'(2'b00);
      e_ready = !e_valid || (head.last && sout_ready);
      chk("sout_valid", sout_valid, e_valid);
      chk("busy",       busy,       e_valid);
      chk("sout",       sout,       head.b);
      chk("sout_last",  sout_last,  head.last);
      chk("din_ready",  din_ready,  e_ready);
      if (e_valid && sout_ready) void'(exp_q.pop_front());
      if (din_valid && e_ready) begin
        for (int k = 0; k < 8; k++) begin
          exp_q.push_back('{b: din[7-k], last: (k == 7)});
        end
      end
    end
  end

  // Offer a word and hold it until accepted. Called and returns at posedge+1.
  task automatic send(input logic [7:0] w);
    bit got;
    got       = 1'b0;
    din       = w;
    din_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (din_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      n_err++;
      $display("FAIL accept_timeout: got no din_ready expected din_ready within 200 cycles");
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  // One word through a directed-check DUT with sout_ready tied high.
  task automatic run_lsb(input logic [7:0] w);
    l_din   = w;
    l_valid = 1'b1;
    @(negedge clk);
    chk("lsb_din_ready_idle", l_dready, 1'b1);
    @(posedge clk);
    #1;
    l_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("lsb_sout",   l_sout,   w[k]);
      chk("lsb_valid",  l_svalid, 1'b1);
      chk("lsb_last",   l_slast,  (k == 7));
    end
    @(negedge clk);
    chk("lsb_idle_after", l_svalid, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_w2(input logic [1:0] w);
    w_din   = w;
    w_valid = 1'b1;
    @(posedge clk);
    #1;
    w_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("w2_sout",      w_sout,   w[1-k]);
      chk("w2_valid",     w_svalid, 1'b1);
      chk("w2_last",      w_slast,  (k == 1));
      chk("w2_din_ready", w_dready, (k == 1));
    end
    @(negedge clk);
    chk("w2_idle_after", w_busy, 1'b0);
    @(posedge clk);
    #1;
  endtask

  bit done;

  initial begin
    rst_n      = 1'b0;
    din        = '0;
    din_valid  = 1'b0;
    sout_ready = 1'b1;
    l_din = '0; l_valid = 1'b0; l_sready = 1'b1;
    w_din = '0; w_valid = 1'b0; w_sready = 1'b1;
    done  = 1'b0;

    // Reset values, no clock edge needed
    #3;
    chk("rst_sout",       sout,       1'b0);
    chk("rst_sout_valid", sout_valid, 1'b0);
    chk("rst_sout_last",  sout_last,  1'b0);
    chk("rst_busy",       busy,       1'b0);
    chk("rst_din_ready",  din_ready,  1'b1);
    chk("rst_lsb_ready",  l_dready,   1'b1);
    chk("rst_w2_valid",   w_svalid,   1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single word, then back-to-back pair with valid held
    send(8'hA5);
    repeat (9) begin @(posedge clk); #1; end
    send(8'hA5);
    send(8'h3C);
    repeat (9) begin @(posedge clk); #1; end

    // Stall for 3 cycles after two bits have gone
    send(8'hF0);
    repeat (2) @(posedge clk);
    #1;
    sout_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sout_ready = 1'b1;
    repeat (8) begin @(posedge clk); #1; end

    // Asynchronous reset mid-frame
    send(8'hFF);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sout",      sout,       1'b0);
    chk("async_rst_valid",     sout_valid, 1'b0);
    chk("async_rst_busy",      busy,       1'b0);
    chk("async_rst_din_ready", din_ready,  1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_din_ready", din_ready, 1'b1);
    send(8'h81);
    repeat (9) begin @(posedge clk); #1; end

    // Randomized words, gaps and back-pressure
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          send(8'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          sout_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    sout_ready = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    chk("drain_empty", exp_q.size(), 0);

    // LSB-first and WIDTH=2 instances
    run_lsb(8'h01);
    for (int n = 0; n < 3; n++) run_lsb(8'($urandom));
    run_w2(2'b10);
    for (int n = 0; n < 3; n++) run_w2(2'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_piso_serializer
`default_nettype wire
